// File: rtl/fifo_burst_pkg.sv
// Shared types and width helpers for the FIFO read-side burst drain engine.
package fifo_burst_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH       = 8;
  localparam int unsigned DEF_FIFO_DEPTH_WIDTH = 11;
  localparam int unsigned DEF_BURST_LEN        = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES   = 255;

  // words_left must hold the value BURST_LEN itself
  function automatic int unsigned words_left_width(input int unsigned burst_len);
    return $clog2(burst_len + 1);
  endfunction

  function automatic int unsigned timer_width(input int unsigned timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/fifo_burst_reader_skid.sv
// Two-entry valid/ready buffer; exposes occupancy so the producer can gate pushes.
module stream_skid_buffer #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic             pop_c;

  assign pop_c     = (occ_q != 2'd0) && out_ready;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = head_q;
  assign occupancy = occ_q;

  // Pop is applied first so a same-cycle push lands in the freed slot
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (pop_c) begin
      if (occ_q == 2'd2) head_d = tail_q;
      occ_d = occ_q - 2'd1;
    end
    if (push) begin
      if (occ_d == 2'd0) head_d = push_data;
      else               tail_d = push_data;
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a FWFT FIFO read port into a valid/ready stream grouped in bursts,
// flushing a partial burst after an idle timeout.
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH_WIDTH = DEF_FIFO_DEPTH_WIDTH,
  parameter int unsigned BURST_LEN        = DEF_BURST_LEN,
  parameter int unsigned TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
  input  logic                        clk_read,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        fifo_empty,
  input  logic [DATA_WIDTH-1:0]       fifo_data_read,
  input  logic [FIFO_DEPTH_WIDTH-1:0] fifo_count,
  output logic                        fifo_read,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_valid,
  output logic                        m_last,
  input  logic                        m_ready,
  output logic                        burst_active,
  output logic [15:0]                 bursts_done
);

  localparam int unsigned WL_W  = words_left_width(BURST_LEN);
  localparam int unsigned TMR_W = timer_width(TIMEOUT_CYCLES);
  localparam int unsigned OCC_W = FIFO_DEPTH_WIDTH + 1;

  localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(1) << FIFO_DEPTH_WIDTH;
  localparam logic [OCC_W-1:0] BURST_OCC = OCC_W'(BURST_LEN);
  localparam logic [WL_W-1:0]  BURST_WL  = WL_W'(BURST_LEN);
  localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  logic [WL_W-1:0]    words_left_q, words_left_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [15:0]        bursts_done_q, bursts_done_d;
  logic [OCC_W-1:0]   occ_eff;
  logic [1:0]         buf_occ;
  logic               pop_c;
  logic               push_last;
  logic [DATA_WIDTH:0] buf_out;

  // A zero count with a non-empty flag is the wrapped encoding of a full FIFO
  assign occ_eff = (fifo_count == '0 && !fifo_empty) ? FULL_OCC : {1'b0, fifo_count};

  assign pop_c     = (state_q == BURST) && (words_left_q != '0) && !fifo_empty
                     && (buf_occ < 2'd2);
  assign push_last = (words_left_q == WL_W'(1));

  assign fifo_read    = pop_c;
  assign burst_active = (state_q == BURST);
  assign bursts_done  = bursts_done_q;
  assign m_last       = buf_out[DATA_WIDTH];
  assign m_data       = buf_out[DATA_WIDTH-1:0];

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    timer_d      = '0;
    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty)
          timer_d = (timer_q == TMR_MAX) ? TMR_MAX : timer_q + TMR_W'(1);
        if (enable && occ_eff >= BURST_OCC) begin
          state_d      = BURST;
          words_left_d = BURST_WL;
          timer_d      = '0;
        end else if (enable && !fifo_empty && timer_q == TMR_MAX) begin
          state_d      = BURST;
          words_left_d = WL_W'(occ_eff);
          timer_d      = '0;
        end
      end
      BURST: begin
        // An empty FIFO just stalls here; the burst is never truncated
        if (pop_c) begin
          words_left_d = words_left_q - WL_W'(1);
          if (push_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bursts_done_d = bursts_done_q;
    if (m_valid && m_ready && m_last) bursts_done_d = bursts_done_q + 16'd1;
  end

  always_ff @(posedge clk_read or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      words_left_q  <= '0;
      timer_q       <= '0;
      bursts_done_q <= '0;
    end else begin
      state_q       <= state_d;
      words_left_q  <= words_left_d;
      timer_q       <= timer_d;
      bursts_done_q <= bursts_done_d;
    end
  end

  stream_skid_buffer #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk       (clk_read),
    .rst       (rst),
    .push      (pop_c),
    .push_data ({push_last, fifo_data_read}),
    .out_valid (m_valid),
    .out_data  (buf_out),
    .out_ready (m_ready),
    .occupancy (buf_occ)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: behavioural FWFT FIFO model,
// output scoreboard, a cycle table for the first burst and hand-written corner cases.
module tb_fifo_burst_reader;

  localparam int unsigned DW  = 8;
  localparam int unsigned FDW = 2;
  localparam int unsigned BL  = 4;
  localparam int unsigned TO  = 5;

  logic           clk_read = 1'b0;
  logic           rst;
  logic           enable;
  logic           fifo_empty;
  logic [DW-1:0]  fifo_data_read;
  logic [FDW-1:0] fifo_count;
  logic           fifo_read;
  logic [DW-1:0]  m_data;
  logic           m_valid;
  logic           m_last;
  logic           m_ready;
  logic           burst_active;
  logic [15:0]    bursts_done;

  always #5 clk_read = ~clk_read;

  fifo_burst_reader #(
    .DATA_WIDTH       (DW),
    .FIFO_DEPTH_WIDTH (FDW),
    .BURST_LEN        (BL),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .clk_read       (clk_read),
    .rst            (rst),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_data_read (fifo_data_read),
    .fifo_count     (fifo_count),
    .fifo_read      (fifo_read),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_last         (m_last),
    .m_ready        (m_ready),
    .burst_active   (burst_active),
    .bursts_done    (bursts_done)
  );

  typedef struct {
    logic          rd;
    logic          ba;
    logic          mv;
    logic [DW-1:0] md;
    logic          ml;
    logic [15:0]   bd;
  } vec_t;

  vec_t           tbl [7];
  logic [DW-1:0]  fq [$];
  logic [DW:0]    sb [$];
  logic [DW:0]    exp_word;
  bit             cnt_force;
  logic [FDW-1:0] cnt_forced;
  bit             rd_s;
  int             pops_seen;
  int             n_checks = 0;
  int             n_pass   = 0;
  int             cyc;
  int             rd_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic void drive_fifo();
    fifo_empty     = (fq.size() == 0);
    fifo_data_read = (fq.size() != 0) ? fq[0] : '0;
    fifo_count     = cnt_force ? cnt_forced : FDW'(fq.size());
  endfunction

  // Words enter the FIFO model and their expected stream image the scoreboard
  task automatic load(input logic [DW-1:0] first, input int n, input bit last_on_end);
    for (int i = 0; i < n; i++) begin
      fq.push_back(first + DW'(i));
      sb.push_back({last_on_end && (i == n - 1), first + DW'(i)});
    end
    drive_fifo();
  endtask

  task automatic sample_half();
    @(negedge clk_read);
    rd_s = fifo_read;
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_word: got last=%0b data=0x%0h, expected no output",
                 m_last, m_data);
      end else begin
        exp_word = sb.pop_front();
        chk("stream_word", 32'({m_last, m_data}), 32'(exp_word));
      end
    end
  endtask

  task automatic advance_half();
    @(posedge clk_read);
    #1;
    if (rd_s) begin
      chk("read_while_empty", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) void'(fq.pop_front());
      pops_seen++;
    end
    drive_fifo();
  endtask

  task automatic step();
    sample_half();
    advance_half();
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((sb.size() != 0 || m_valid) && guard < 40) begin
      step();
      guard++;
    end
    chk({name, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    // Full 4-word burst from a wrapped (count==0, non-empty) FIFO, m_ready high
    tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 16'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 16'd0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 16'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h13, 1'b1, 16'd0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd1};

    rst        = 1'b1;
    enable     = 1'b0;
    m_ready    = 1'b1;
    cnt_force  = 1'b0;
    cnt_forced = '0;
    pops_seen  = 0;
    drive_fifo();
    #2;
    chk("reset_fifo_read", 32'(fifo_read), 32'd0);
    chk("reset_m_valid", 32'(m_valid), 32'd0);
    chk("reset_m_last", 32'(m_last), 32'd0);
    chk("reset_m_data", 32'(m_data), 32'd0);
    chk("reset_burst_active", 32'(burst_active), 32'd0);
    chk("reset_bursts_done", 32'(bursts_done), 32'd0);
    @(posedge clk_read);
    @(posedge clk_read);
    #1;
    rst    = 1'b0;
    enable = 1'b1;
    step();
    step();

    load(8'h10, 4, 1'b1);
    for (int i = 0; i < 7; i++) begin
      sample_half();
      chk($sformatf("tbl%0d_fifo_read", i), 32'(fifo_read), 32'(tbl[i].rd));
      chk($sformatf("tbl%0d_burst_active", i), 32'(burst_active), 32'(tbl[i].ba));
      chk($sformatf("tbl%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].mv));
      if (tbl[i].mv) begin
        chk($sformatf("tbl%0d_m_data", i), 32'(m_data), 32'(tbl[i].md));
        chk($sformatf("tbl%0d_m_last", i), 32'(m_last), 32'(tbl[i].ml));
      end
      chk($sformatf("tbl%0d_bursts_done", i), 32'(bursts_done), 32'(tbl[i].bd));
      advance_half();
    end
    chk("full_burst_sb_empty", 32'(sb.size()), 32'd0);

    // enable low holds off the timeout; then a 2-word flush after TO+1 cycles
    enable = 1'b0;
    load(8'h20, 2, 1'b1);
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rd_s) rd_cnt++;
    end
    chk("disabled_no_pop", 32'(rd_cnt), 32'd0);
    enable = 1'b1;
    cyc = 0;
    sample_half();
    while (!fifo_read && cyc < 30) begin
      advance_half();
      cyc++;
      sample_half();
    end
    advance_half();
    chk("timeout_first_pop_cycle", 32'(cyc), 32'(TO + 1));
    drain("timeout");
    chk("timeout_bursts_done", 32'(bursts_done), 32'd2);

    // Backpressure: only two pops fit before fifo_read drops
    m_ready   = 1'b0;
    pops_seen = 0;
    load(8'h30, 4, 1'b1);
    for (int i = 0; i < 8; i++) step();
    chk("bp_pops", 32'(pops_seen), 32'd2);
    chk("bp_fifo_read_low", 32'(fifo_read), 32'd0);
    chk("bp_m_valid_held", 32'(m_valid), 32'd1);
    chk("bp_m_data_held", 32'(m_data), 32'h30);
    chk("bp_burst_active", 32'(burst_active), 32'd1);
    m_ready = 1'b1;
    drain("backpressure");
    chk("bp_bursts_done", 32'(bursts_done), 32'd3);
    chk("bp_fifo_consumed", 32'(fq.size()), 32'd0);

    // Three words wait for timeout; the fourth wraps count to 0 = full
    load(8'h40, 3, 1'b0);
    rd_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (rd_s) rd_cnt++;
    end
    chk("partial_no_pop", 32'(rd_cnt), 32'd0);
    load(8'h43, 1, 1'b1);
    chk("full_encode_count", 32'(fifo_count), 32'd0);
    sample_half();
    chk("full_encode_idle", 32'(fifo_read), 32'd0);
    advance_half();
    sample_half();
    chk("full_encode_start", 32'(fifo_read), 32'd1);
    advance_half();
    drain("full_encode");
    chk("full_encode_bursts_done", 32'(bursts_done), 32'd4);

    // Stale full count with only 2 words: stall mid-burst, then resume
    cnt_force  = 1'b1;
    cnt_forced = '0;
    pops_seen  = 0;
    load(8'h50, 2, 1'b0);
    for (int i = 0; i < 12 && pops_seen < 2; i++) step();
    for (int i = 0; i < 4; i++) step();
    chk("underflow_pops", 32'(pops_seen), 32'd2);
    chk("underflow_burst_active", 32'(burst_active), 32'd1);
    chk("underflow_fifo_read", 32'(fifo_read), 32'd0);
    chk("underflow_bursts_done", 32'(bursts_done), 32'd4);
    cnt_force = 1'b0;
    load(8'h52, 2, 1'b1);
    drain("underflow");
    chk("underflow_resume_done", 32'(bursts_done), 32'd5);
    chk("underflow_back_idle", 32'(burst_active), 32'd0);

    // Asynchronous reset between edges mid-burst
    load(8'h60, 4, 1'b1);
    step();
    step();
    step();
    chk("prerst_m_valid", 32'(m_valid), 32'd1);
    chk("prerst_fifo_read", 32'(fifo_read), 32'd1);
    chk("prerst_burst_active", 32'(burst_active), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_fifo_read", 32'(fifo_read), 32'd0);
    chk("rst_burst_active", 32'(burst_active), 32'd0);
    chk("rst_bursts_done", 32'(bursts_done), 32'd0);
    fq.delete();
    sb.delete();
    drive_fifo();
    @(posedge clk_read);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("postrst_idle", 32'(burst_active), 32'd0);
    chk("postrst_no_valid", 32'(m_valid), 32'd0);
    load(8'h70, 4, 1'b1);
    drain("postrst");
    chk("postrst_bursts_done", 32'(bursts_done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

endmodule
